// File: rtl/spi_slave_phy.sv
// SPI mode-0 slave PHY: synchronizes the SPI pins into clk, assembles 16-bit RX frames and serializes TX replies.
// Define SPI_MISO_TRISTATE_EN to release spi_miso to high-Z outside an active frame.
module spi_slave_phy #(
    parameter int unsigned FRAME_BITS  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_sclk,
    input  logic                  spi_cs_n,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    output logic                  rx_data_ready,
    output logic [FRAME_BITS-1:0] rx_data,
    input  logic                  tx_data_ready,
    input  logic [FRAME_BITS-1:0] tx_data,
    output logic                  spi_clk_error
);

    localparam int unsigned CNT_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES:0]   flush;
    logic                   sclk_q;
    logic                   cs_q;
    logic                   armed;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] rx_shift;
    logic [FRAME_BITS-1:0] tx_shift;
    logic [FRAME_BITS-1:0] pend_data;
    logic                  pend_valid;

    logic load_tx, shift_rx, shift_tx, frame_done, err_det;

    // Pin synchronizers; reset values model an idle bus (cs_n high, sclk/mosi low).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
        end
    end

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    // Edge history, plus an arm flag so a cs_n already low at reset release never opens a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= 1'b0;
            cs_q   <= 1'b1;
            flush  <= '0;
            armed  <= 1'b0;
        end else begin
            sclk_q <= sclk_s;
            cs_q   <= cs_s;
            flush  <= {flush[SYNC_STAGES-1:0], 1'b1};
            if (flush[SYNC_STAGES] && cs_s) begin
                armed <= 1'b1;
            end
        end
    end

    assign sclk_rise = sclk_s & ~sclk_q;
    assign sclk_fall = ~sclk_s & sclk_q;
    assign cs_rise   = cs_s & ~cs_q;
    assign cs_fall   = armed & cs_q & ~cs_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle datapath strobes.
    always_comb begin
        state_d    = state_q;
        load_tx    = 1'b0;
        shift_rx   = 1'b0;
        shift_tx   = 1'b0;
        frame_done = 1'b0;
        err_det    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    load_tx = 1'b1;
                    err_det = sclk_s;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                    err_det = (bit_cnt != '0);
                end else begin
                    if (sclk_rise) begin
                        shift_rx = 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                            frame_done = 1'b1;
                            load_tx    = 1'b1;
                        end
                    end
                    // The falling edge that closes a frame must not consume the reloaded MSB.
                    if (sclk_fall && (bit_cnt != '0)) begin
                        shift_tx = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Receive path: bit counter, shift register and frame hand-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt       <= '0;
            rx_shift      <= '0;
            rx_data       <= '0;
            rx_data_ready <= 1'b0;
            spi_clk_error <= 1'b0;
        end else begin
            rx_data_ready <= frame_done;
            spi_clk_error <= err_det;
            if (state_q == IDLE) begin
                bit_cnt <= '0;
            end else if (shift_rx) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (shift_rx) begin
                rx_shift <= {rx_shift[FRAME_BITS-2:0], mosi_s};
            end
            if (frame_done) begin
                rx_data <= {rx_shift[FRAME_BITS-2:0], mosi_s};
            end
        end
    end

    // Transmit path: pending reply buffer and MSB-first shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_shift   <= '0;
            pend_data  <= '0;
            pend_valid <= 1'b0;
        end else begin
            if (load_tx) begin
                pend_valid <= 1'b0;
                if (tx_data_ready) begin
                    tx_shift <= tx_data;
                end else if (pend_valid) begin
                    tx_shift <= pend_data;
                end else begin
                    tx_shift <= '0;
                end
            end else begin
                if (tx_data_ready) begin
                    pend_valid <= 1'b1;
                end
                if (shift_tx) begin
                    tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
            if (tx_data_ready) begin
                pend_data <= tx_data;
            end
        end
    end

`ifdef SPI_MISO_TRISTATE_EN
    assign spi_miso = (state_q == ACTIVE) ? tx_shift[FRAME_BITS-1] : 1'bz;
`else
    assign spi_miso = (state_q == ACTIVE) & tx_shift[FRAME_BITS-1];
`endif

endmodule

// File: doc/spi_slave_phy.md
SPI_SLAVE_PHY -- requirements
Module: spi_slave_phy

Interface
REQ-001 Parameter FRAME_BITS, default 16, bits per SPI frame; only 16 is supported.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer depth on spi_sclk/spi_cs_n/spi_mosi; legal values 2 or 3.
REQ-003 clk  input  1  system clock, the single clock of the block; all logic is rising-edge clk.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 spi_sclk  input  1  SPI clock from master, asynchronous to clk, idle low (CPOL=0).
REQ-006 spi_cs_n  input  1  SPI chip select, active low, asynchronous.
REQ-007 spi_mosi  input  1  master-out data, MSB first.
REQ-008 spi_miso  output  1  slave-out data, MSB first.
REQ-009 rx_data_ready  output  1  one-clk pulse: a complete 16-bit frame is on rx_data.
REQ-010 rx_data  output  16  last complete received frame, held until the next frame completes.
REQ-011 tx_data_ready  input  1  one-clk pulse: tx_data is to be sent in the next frame.
REQ-012 tx_data  input  16  reply word, sampled only when tx_data_ready=1.
REQ-013 spi_clk_error  output  1  one-clk pulse on a protocol error.

Function
REQ-014 spi_sclk, spi_cs_n and spi_mosi SHALL pass through SYNC_STAGES flops; edges are detected on the synchronized signals; supported spi_sclk frequency is at most clk/8.
REQ-015 Two states: IDLE (synchronized cs_n=1) and ACTIVE (synchronized cs_n=0); IDLE->ACTIVE on cs_n falling edge, ACTIVE->IDLE on cs_n rising edge.
REQ-016 On IDLE->ACTIVE the bit counter SHALL clear to 0, and the TX shift register SHALL load the pending word (or 0x0000 if none is pending).
REQ-017 In ACTIVE, each synchronized sclk rising edge SHALL shift spi_mosi into the RX shift register LSB and increment the 4-bit bit counter.
REQ-018 The counter wraps 15->0; on the 16th rising edge, rx_data SHALL take the assembled word and rx_data_ready SHALL pulse exactly one clk later, aligned with rx_data being valid.
REQ-019 On counter wrap with cs_n still low (back-to-back frames), the TX shift register SHALL reload the pending word (or 0x0000) before the next falling sclk edge.
REQ-020 In ACTIVE, each synchronized sclk falling edge SHALL shift the TX register left; spi_miso = TX register bit 15 at all times in ACTIVE, so the MSB is valid before the first rising edge.
REQ-021 A tx_data_ready pulse SHALL latch tx_data into a pending buffer and set a pending flag; a load into the shift register clears the flag; a later tx_data_ready before the load overwrites the buffer.
REQ-022 If tx_data_ready coincides with a shift-register load, the new word SHALL be the word loaded (bypass); the flag then stays clear.
REQ-023 spi_clk_error SHALL pulse for one clk on either: cs_n rising while the bit counter is nonzero (partial frame, no rx_data_ready, rx_data unchanged); or cs_n falling while synchronized sclk=1 (wrong polarity).
REQ-024 sclk edges while in IDLE SHALL be ignored.
REQ-025 In IDLE, spi_miso SHALL be 0 (see REQ-029).

Reset
REQ-026 On rst_n=0: state IDLE, bit counter 0, rx_data 0x0000, rx_data_ready 0, spi_clk_error 0, TX shift register 0x0000, pending flag 0, synchronizer flops set to cs_n=1 and sclk=0/mosi=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_data_ready and no spi_clk_error; after release, the block SHALL wait for a fresh cs_n falling edge.
REQ-028 A held-low cs_n at reset release SHALL NOT create an ACTIVE frame.

Configuration
REQ-029 Macro SPI_MISO_TRISTATE_EN: when defined, spi_miso SHALL be high-Z in IDLE and during reset; when undefined, spi_miso SHALL be driven 0 in IDLE and during reset; ACTIVE behaviour SHALL be identical in both builds.

Verification
REQ-030 cs_n low, 16 clocks of 0x0003 at clk/8, cs_n high -> one rx_data_ready pulse with rx_data=0x0003; miso=0x0000; no spi_clk_error.
REQ-031 Frame 0xC001; on rx_data_ready, drive tx_data_ready with tx_data=0x000A; then a second frame 0x0000 -> miso bits read 0x000A and rx_data=0x0000.
REQ-032 Two frames 0x0011, 0x1234 under one continuous cs_n low -> two rx_data_ready pulses with 0x0011 then 0x1234.
REQ-033 cs_n low, 9 sclk cycles, cs_n high -> spi_clk_error pulse, no rx_data_ready, rx_data retains its prior value.
REQ-034 cs_n falls while sclk=1 -> spi_clk_error pulse; rst_n pulsed low mid-frame -> all outputs at reset values and the next full frame 0xBEEF is received correctly.
REQ-035 Both builds: with cs_n high, spi_miso=Z when SPI_MISO_TRISTATE_EN is defined and 0 otherwise.
